settings_menu: RTL and testbench

Parametrised front-panel settings controller: three push switches drive a cursor over NUM_FIELDS editable fields, each with its own wrap limit. All switch inputs are synchronised, debounced and edge-detected in the `clk` domain, so no logic is clocked by a switch. Edits go to a shadow copy. Committed values change only when selection mode is left, marked by a one-cycle `commit` pulse. Sits between the board switch pins and the game core and display, which consume `fields` for mode, map and similar settings.

---
 rtl/settings_menu_if.sv | 41 ++++
 rtl/settings_menu.sv | 136 +++++++++++++
 tb/tb_settings_menu.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/settings_menu_if.sv
// settings_menu_if
//   Groups the switch inputs and the settings outputs of settings_menu.
//   master : front-panel / testbench side (drives switch, observes outputs)
//   slave  : settings_menu side (consumes switch, drives outputs)
//   switch     [2:0]                 raw switch levels ([2] select, [1] cursor, [0] value)
//   selecting                        debounced select level, 1 = edit mode
//   cursor     [CUR_W-1:0]           field under edit
//   fields     [NUM_FIELDS*FIELD_W]  committed values
//   edit_value [FIELD_W-1:0]         shadow value at cursor
//   commit                           one-cycle pulse on shadow->fields copy
interface settings_menu_if #(
    parameter int unsigned NUM_FIELDS = 2,
    parameter int unsigned FIELD_W    = 2
);
    localparam int unsigned CUR_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    logic [2:0]                    switch;
    logic                          selecting;
    logic [CUR_W-1:0]              cursor;
    logic [NUM_FIELDS*FIELD_W-1:0] fields;
    logic [FIELD_W-1:0]            edit_value;
    logic                          commit;

    modport master (
        output switch,
        input  selecting,
        input  cursor,
        input  fields,
        input  edit_value,
        input  commit
    );

    modport slave (
        input  switch,
        output selecting,
        output cursor,
        output fields,
        output edit_value,
        output commit
    );
endinterface

// File: rtl/settings_menu.sv
// settings_menu
//   Front-panel settings controller. Three raw switches are synchronised,
//   debounced and edge-detected in the clk domain. While select is high the
//   cursor and value switches edit a shadow copy of the fields; the falling
//   edge of select copies the shadow to the committed fields with a
//   one-cycle commit pulse.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-low reset
//     bus  settings_menu_if.slave (switch in; selecting, cursor, fields,
//          edit_value, commit out)
module settings_menu #(
    parameter int unsigned                    NUM_FIELDS      = 2,
    parameter int unsigned                    FIELD_W         = 2,
    parameter logic [NUM_FIELDS*FIELD_W-1:0]  FIELD_MAX_VEC   = {2'd2, 2'd1},
    parameter int unsigned                    DEBOUNCE_CYCLES = 1000000
) (
    input  logic           clk,
    input  logic           rst,
    settings_menu_if.slave bus
);
    localparam int unsigned CUR_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(NUM_FIELDS - 1);
    // Select path idles high so that edit mode is active out of reset.
    localparam logic [2:0]       SW_RST   = 3'b100;

    logic [2:0]       r_s1;
    logic [2:0]       r_s2;
    logic [2:0]       r_db;
    logic [2:0]       r_db_prev;
    logic [CNT_W-1:0] r_cnt [3];

    logic [2:0]       w_rise;
    logic             w_fall_sel;

    logic [CUR_W-1:0]              r_cursor;
    logic [FIELD_W-1:0]            r_shadow [NUM_FIELDS];
    logic [NUM_FIELDS*FIELD_W-1:0] r_fields;
    logic                          r_commit;

    logic [NUM_FIELDS*FIELD_W-1:0] w_shadow_flat;
    logic [FIELD_W-1:0]            w_edit_value;

    // Synchroniser and per-bit debounce. The level only moves after the
    // synchronised input has differed for DEBOUNCE_CYCLES consecutive cycles;
    // any return to the current level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1      <= SW_RST;
            r_s2      <= SW_RST;
            r_db      <= SW_RST;
            r_db_prev <= SW_RST;
            for (int unsigned b = 0; b < 3; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            r_s1      <= bus.switch;
            r_s2      <= r_s1;
            r_db_prev <= r_db;
            for (int unsigned b = 0; b < 3; b++) begin
                if (r_s2[b] == r_db[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == CNT_LAST) begin
                    r_db[b]  <= r_s2[b];
                    r_cnt[b] <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign w_rise     = r_db & ~r_db_prev;
    assign w_fall_sel = ~r_db[2] & r_db_prev[2];

    always_comb begin
        w_shadow_flat = '0;
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            w_shadow_flat[i*FIELD_W +: FIELD_W] = r_shadow[i];
        end
    end

    always_comb begin
        w_edit_value = '0;
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            if (r_cursor == CUR_W'(i)) begin
                w_edit_value = r_shadow[i];
            end
        end
    end

    // Leaving select mode wins over any edit in the same cycle. A value
    // increment and a cursor advance together touch the old cursor field,
    // since both read r_cursor before it updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cursor <= '0;
            r_fields <= '0;
            r_commit <= 1'b0;
            for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_commit <= 1'b0;
            if (w_fall_sel) begin
                r_fields <= w_shadow_flat;
                r_commit <= 1'b1;
            end else if (r_db[2]) begin
                if (w_rise[0]) begin
                    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
                        if (r_cursor == CUR_W'(i)) begin
                            // >= also recovers a value left above an inconsistent max
                            if (r_shadow[i] >= FIELD_MAX_VEC[i*FIELD_W +: FIELD_W]) begin
                                r_shadow[i] <= '0;
                            end else begin
                                r_shadow[i] <= r_shadow[i] + 1'b1;
                            end
                        end
                    end
                end
                if (w_rise[1]) begin
                    r_cursor <= (r_cursor == CUR_LAST) ? '0 : r_cursor + 1'b1;
                end
            end
        end
    end

    assign bus.selecting  = r_db[2];
    assign bus.cursor     = r_cursor;
    assign bus.fields     = r_fields;
    assign bus.edit_value = w_edit_value;
    assign bus.commit     = r_commit;
endmodule

// File: tb/tb_settings_menu.sv
module tb_settings_menu;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   commit_cnt;
    int   commit_at;
    logic [3:0] fields_at_commit;

    settings_menu_if #(.NUM_FIELDS(2), .FIELD_W(2)) bus ();

    settings_menu #(
        .NUM_FIELDS     (2),
        .FIELD_W        (2),
        .FIELD_MAX_VEC  (4'b1001),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raise the given switch bits, hold past the debounce, then drop them.
    task automatic press(input logic [2:0] bits);
        bus.switch = bus.switch | bits;
        tick(8);
        bus.switch = bus.switch & ~bits;
        tick(8);
    endtask

    // Watch for commit pulses over n cycles after an input change.
    task automatic watch_commit(input int n);
        commit_cnt = 0;
        commit_at  = 0;
        fields_at_commit = '0;
        for (int i = 1; i <= n; i++) begin
            tick(1);
            if (bus.commit === 1'b1) begin
                commit_cnt++;
                commit_at = i;
                fields_at_commit = bus.fields;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.switch = 3'b100;
        tick(3);
        chk("rst_selecting", 32'(bus.selecting), 1);
        chk("rst_cursor",    32'(bus.cursor), 0);
        chk("rst_fields",    32'(bus.fields), 0);
        chk("rst_edit",      32'(bus.edit_value), 0);
        chk("rst_commit",    32'(bus.commit), 0);

        rst = 1'b1;
        watch_commit(12);
        chk("rel_no_commit", 32'(commit_cnt), 0);
        chk("rel_selecting", 32'(bus.selecting), 1);

        // Short pulse: three synchronised cycles is one short of the debounce
        bus.switch[1] = 1'b1;
        tick(3);
        bus.switch[1] = 1'b0;
        tick(10);
        chk("short_pulse_cursor", 32'(bus.cursor), 0);

        // Latency: action lands on the seventh edge (edge 6) after the change
        bus.switch[1] = 1'b1;
        tick(6);
        chk("lat_edge5_cursor", 32'(bus.cursor), 0);
        tick(1);
        chk("lat_edge6_cursor", 32'(bus.cursor), 1);
        tick(4);
        bus.switch[1] = 1'b0;
        tick(8);

        press(3'b010);
        chk("cursor_wrap", 32'(bus.cursor), 0);

        // Field 1 max = 2
        press(3'b010);
        chk("cursor_to1", 32'(bus.cursor), 1);
        press(3'b001);
        chk("f1_inc1", 32'(bus.edit_value), 1);
        press(3'b001);
        chk("f1_inc2", 32'(bus.edit_value), 2);
        press(3'b001);
        chk("f1_wrap", 32'(bus.edit_value), 0);
        chk("f1_fields", 32'(bus.fields), 0);

        // Field 0 max = 1
        press(3'b010);
        chk("cursor_to0", 32'(bus.cursor), 0);
        press(3'b001);
        chk("f0_inc1", 32'(bus.edit_value), 1);
        press(3'b001);
        chk("f0_wrap", 32'(bus.edit_value), 0);
        chk("f0_fields", 32'(bus.fields), 0);

        // Commit shadow1=1
        press(3'b010);
        press(3'b001);
        chk("pre_commit_edit", 32'(bus.edit_value), 1);
        bus.switch[2] = 1'b0;
        watch_commit(14);
        chk("commit_pulses",    32'(commit_cnt), 1);
        chk("commit_edge",      32'(commit_at), 7);
        chk("commit_fields_at", 32'(fields_at_commit), 32'h4);
        chk("commit_fields",    32'(bus.fields), 32'h4);
        chk("commit_selecting", 32'(bus.selecting), 0);

        // Outside selection edits are ignored and not queued
        press(3'b001);
        press(3'b010);
        chk("idle_fields", 32'(bus.fields), 32'h4);
        chk("idle_cursor", 32'(bus.cursor), 1);
        chk("idle_edit",   32'(bus.edit_value), 1);
        bus.switch[2] = 1'b1;
        watch_commit(10);
        chk("reenter_selecting", 32'(bus.selecting), 1);
        chk("reenter_edit",      32'(bus.edit_value), 1);
        chk("reenter_cursor",    32'(bus.cursor), 1);
        chk("reenter_no_commit", 32'(commit_cnt), 0);

        // Cursor and value rise together: increment old field, then advance
        press(3'b010);
        chk("sim_pre_cursor", 32'(bus.cursor), 0);
        press(3'b011);
        chk("sim_cursor", 32'(bus.cursor), 1);
        chk("sim_edit_f1", 32'(bus.edit_value), 1);
        press(3'b010);
        chk("sim_edit_f0", 32'(bus.edit_value), 1);

        // Select fall with value rise: commit pre-edit shadow, edit discarded
        bus.switch = 3'b001;
        watch_commit(14);
        chk("fall_val_pulses", 32'(commit_cnt), 1);
        chk("fall_val_fields", 32'(bus.fields), 32'h5);
        chk("fall_val_edit",   32'(bus.edit_value), 1);
        bus.switch = 3'b000;
        tick(8);

        // Reset mid-edit with a commit pending
        bus.switch = 3'b100;
        tick(10);
        press(3'b010);
        press(3'b001);
        chk("mid_edit_value", 32'(bus.edit_value), 2);
        bus.switch = 3'b000;
        tick(3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_selecting", 32'(bus.selecting), 1);
        chk("arst_cursor",    32'(bus.cursor), 0);
        chk("arst_fields",    32'(bus.fields), 0);
        chk("arst_edit",      32'(bus.edit_value), 0);
        chk("arst_commit",    32'(bus.commit), 0);
        bus.switch = 3'b100;
        tick(3);
        rst = 1'b1;
        watch_commit(12);
        chk("arst_no_commit",   32'(commit_cnt), 0);
        chk("arst_fields_hold", 32'(bus.fields), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
